// File: rtl/sha_mem_responder.sv
// rtl/sha_mem_responder.sv - shared memory, host message loader and digest streamer for simplified_sha256
// Define SHA_MEM_RESP_CHECK_EN to build the write-mask tracker and the sticky err flag.
module sha_mem_responder #(
  parameter int          DEPTH        = 256,
  parameter int          NUM_OF_WORDS = 20,
  parameter logic [15:0] MSG_BASE     = 16'h0000,
  parameter logic [15:0] OUT_BASE     = 16'h0080
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        start,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        done,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        err
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [16:0] DEPTH_L   = 17'(DEPTH);
  localparam logic [15:0] LAST_WORD = 16'(NUM_OF_WORDS - 1);

  typedef enum logic [2:0] {S_LOAD, S_START, S_ARM, S_RUN, S_DRAIN} state_t;
  state_t state, state_nxt;

  logic [31:0]   mem [DEPTH];
  logic [15:0]   cnt;
  logic [2:0]    k;
  logic [2:0]    k_sel;
  logic [1:0]    arm_cnt;
  logic          eng_in_range, eng_wr, host_wr, out_hs;
  logic [AW-1:0] host_idx, drain_idx;

  assign eng_in_range = {1'b0, mem_addr} < DEPTH_L;
  assign eng_wr       = mem_we && eng_in_range;
  assign host_wr      = in_valid && (state == S_LOAD);
  assign host_idx     = AW'(MSG_BASE + cnt);
  assign out_hs       = out_valid && out_ready;
  assign k_sel        = out_hs ? k + 3'd1 : k;
  assign drain_idx    = AW'(OUT_BASE + {13'd0, k_sel});

  assign in_ready     = (state == S_LOAD);
  assign busy         = (state != S_LOAD);
  assign start        = (state == S_START);
  assign message_addr = MSG_BASE;
  assign output_addr  = OUT_BASE;

  // Engine write is issued last so it wins a same-address collision with the host.
  always_ff @(posedge clk) begin
    if (host_wr) mem[host_idx] <= in_data;
    if (eng_wr)  mem[mem_addr[AW-1:0]] <= mem_write_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_read_data <= '0;
    else          mem_read_data <= eng_in_range ? mem[mem_addr[AW-1:0]] : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_LOAD;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (host_wr && cnt == LAST_WORD) state_nxt = S_START;
      S_START: state_nxt = S_ARM;
      S_ARM:   if (!done || arm_cnt == 2'd3) state_nxt = S_RUN;
      S_RUN:   if (done) state_nxt = S_DRAIN;
      S_DRAIN: if (out_hs && k == 3'd7) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  // Digest output register reloads on each handshake so a ready host sees one word per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      k         <= '0;
      arm_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (host_wr) cnt <= (cnt == LAST_WORD) ? '0 : cnt + 16'd1;
      arm_cnt <= (state == S_ARM) ? arm_cnt + 2'd1 : 2'd0;
      if (state != S_DRAIN) begin
        k         <= '0;
        out_valid <= 1'b0;
      end else if (out_hs && k == 3'd7) begin
        out_valid <= 1'b0;
      end else if (!out_valid || out_ready) begin
        k         <= k_sel;
        out_valid <= 1'b1;
        out_data  <= mem[drain_idx];
      end
    end
  end

`ifdef SHA_MEM_RESP_CHECK_EN
  logic [7:0]  wmask, wmask_nxt;
  logic [15:0] out_off;
  logic        oor, timeout, short_mask, collide;

  assign out_off = mem_addr - OUT_BASE;

  always_comb begin
    wmask_nxt = wmask;
    if (state == S_RUN && mem_we && mem_addr >= OUT_BASE && out_off < 16'd8)
      wmask_nxt[out_off[2:0]] = 1'b1;
  end

  assign oor        = !eng_in_range && (mem_we || state == S_RUN);
  assign timeout    = (state == S_ARM) && done && (arm_cnt == 2'd3);
  assign short_mask = (state == S_RUN) && done && (wmask_nxt != 8'hFF);
  assign collide    = host_wr && eng_wr && (host_idx == mem_addr[AW-1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wmask <= '0;
      err   <= 1'b0;
    end else begin
      wmask <= (state == S_START) ? 8'h00 : wmask_nxt;
      if (oor || timeout || short_mask || collide) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
